// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace buffer. Defining TRACE_REGFILE_EN adds the
// r1/r31 register snapshots to every trace entry.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic        zero;
`ifdef TRACE_REGFILE_EN
        logic [31:0] r1;
        logic [31:0] r31;
`endif
    } trace_entry_t;

`ifdef TRACE_REGFILE_EN
    localparam int ENTRY_W = 161;
`else
    localparam int ENTRY_W = 97;
`endif

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x ENTRY_W register array, synchronous write and
// asynchronous read so the drain port can present buffer[rd_ptr] directly.
module trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of CPU commit signals, stopped by a PC trigger and
// drained oldest-first over valid/ready. TRACE_REGFILE_EN adds r1/r31 fields.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int POST_CNT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          cap_en,
    input  logic [31:0]   trig_pc,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   inst_in,
    input  logic [31:0]   alu_in,
    input  logic          zero_in,
`ifdef TRACE_REGFILE_EN
    input  logic [31:0]   r1_in,
    input  logic [31:0]   r31_in,
    output logic [31:0]   rd_r1,
    output logic [31:0]   rd_r31,
`endif
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_inst,
    output logic [31:0]   rd_alu,
    output logic          rd_zero,
    output logic          rd_last,
    output logic [1:0]    state_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] post_q, post_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic          wr_en;
    logic          to_drain;
    trace_entry_t  wr_entry;
    trace_entry_t  rd_entry;

    always_comb begin
        wr_entry.pc   = pc_in;
        wr_entry.inst = inst_in;
        wr_entry.alu  = alu_in;
        wr_entry.zero = zero_in;
`ifdef TRACE_REGFILE_EN
        wr_entry.r1   = r1_in;
        wr_entry.r31  = r31_in;
`endif
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_d      = post_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        wr_en       = 1'b0;
        to_drain    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end
            end
            ST_ARMED: begin
                if (cap_en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (count_q != FULL) count_d = count_q + CNT_ONE;
                    if (pc_in == trig_pc) begin
                        if (POST_CNT == 1) begin
                            to_drain = 1'b1;
                        end else begin
                            post_d  = AW'(POST_CNT - 1);
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (cap_en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (count_q != FULL) count_d = count_q + CNT_ONE;
                    post_d = post_q - AW'(1);
                    if (post_q == AW'(1)) to_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (rd_valid && rd_ready) begin
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Once the buffer has wrapped, the slot about to be overwritten is the oldest.
        if (to_drain) begin
            state_d     = ST_DRAIN;
            remaining_d = count_d;
            rd_ptr_d    = (count_d == FULL) ? wr_ptr_d : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_q      <= '0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_q      <= post_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end

    // Data is gated by rd_valid so the port reads zero whenever nothing is presented.
    assign rd_valid = (state_q == ST_DRAIN) && (remaining_q != '0);
    assign rd_last  = rd_valid && (remaining_q == CNT_ONE);
    assign rd_pc    = rd_valid ? rd_entry.pc   : 32'd0;
    assign rd_inst  = rd_valid ? rd_entry.inst : 32'd0;
    assign rd_alu   = rd_valid ? rd_entry.alu  : 32'd0;
    assign rd_zero  = rd_valid ? rd_entry.zero : 1'b0;
`ifdef TRACE_REGFILE_EN
    assign rd_r1    = rd_valid ? rd_entry.r1   : 32'd0;
    assign rd_r31   = rd_valid ? rd_entry.r31  : 32'd0;
`endif
    assign state_o  = state_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a queue-based model of the captured
// sample stream predicts the drained trace; a monitor checks every accepted entry.
module tb_cpu_trace_buffer;

    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int POST_CNT = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic        zero;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        cap_en = 1'b0;
    logic [31:0] trig_pc = 32'd0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] inst_in = 32'd0;
    logic [31:0] alu_in = 32'd0;
    logic        zero_in = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_alu;
    logic        rd_zero;
    logic        rd_last;
    logic [1:0]  state_o;
    logic [AW:0] count_o;
`ifdef TRACE_REGFILE_EN
    logic [31:0] r1_in = 32'd0;
    logic [31:0] r31_in = 32'd0;
    logic [31:0] rd_r1;
    logic [31:0] rd_r31;
`endif

    int   total = 0;
    int   bad = 0;
    ent_t exp_q[$];

    cpu_trace_buffer #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .POST_CNT (POST_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .cap_en   (cap_en),
        .trig_pc  (trig_pc),
        .pc_in    (pc_in),
        .inst_in  (inst_in),
        .alu_in   (alu_in),
        .zero_in  (zero_in),
`ifdef TRACE_REGFILE_EN
        .r1_in    (r1_in),
        .r31_in   (r31_in),
        .rd_r1    (rd_r1),
        .rd_r31   (rd_r31),
`endif
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_inst  (rd_inst),
        .rd_alu   (rd_alu),
        .rd_zero  (rd_zero),
        .rd_last  (rd_last),
        .state_o  (state_o),
        .count_o  (count_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every accepted entry and checks stall stability.
    initial begin
        bit          stall_prev = 1'b0;
        logic [31:0] held_pc = 32'd0;
        ent_t        e;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                chk("hold_valid", 32'(rd_valid), 32'd1);
                chk("hold_pc", rd_pc, held_pc);
            end
            if (!rst && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_entry: got pc=%h required no entry", rd_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("pop pc=%h inst=%h alu=%h zero=%b last=%b", rd_pc, rd_inst, rd_alu, rd_zero, rd_last);
                    chk("rd_pc", rd_pc, e.pc);
                    chk("rd_inst", rd_inst, e.inst);
                    chk("rd_alu", rd_alu, e.alu);
                    chk("rd_zero", 32'(rd_zero), 32'(e.zero));
                    chk("rd_last", 32'(rd_last), 32'(exp_q.size() == 0));
                end
            end
            stall_prev = !rst && rd_valid && !rd_ready;
            held_pc    = rd_pc;
        end
    end

    // gaps: 0 none, 1 random (trigger sample always qualified), 2 alternate after trigger.
    // abort: pulse rst once the capture is in POST.
    task automatic capture(input logic [31:0] trig, input int gaps, input bit abort, output int keep);
        ent_t        smp[$];
        ent_t        e;
        int          trig_idx = -1;
        int          cyc = 0;
        bit          done = 1'b0;
        bit          en;
        bit          alt = 1'b0;
        logic [31:0] pcv = 32'd0;
        keep = 0;
        @(posedge clk); #1;
        arm = 1'b1;
        trig_pc = trig;
        @(posedge clk); #1;
        arm = 1'b0;
        while (cyc < 200) begin
            if (abort && trig_idx >= 0) begin
                chk("post_state", 32'(state_o), 32'd2);
                cap_en = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort_state", 32'(state_o), 32'd0);
                chk("abort_valid", 32'(rd_valid), 32'd0);
                chk("abort_count", 32'(count_o), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            e.pc   = pcv;
            e.inst = $urandom;
            e.alu  = $urandom;
            e.zero = 1'($urandom_range(0, 1));
            if (trig_idx < 0) begin
                en = (gaps == 1) ? ((pcv == trig) || ($urandom_range(0, 1) == 1)) : 1'b1;
            end else if (gaps == 2) begin
                en  = alt;
                alt = !alt;
            end else if (gaps == 1) begin
                en = ($urandom_range(0, 1) == 1);
            end else begin
                en = 1'b1;
            end
            cap_en  = en;
            pc_in   = e.pc;
            inst_in = e.inst;
            alu_in  = e.alu;
            zero_in = e.zero;
            if (en) begin
                smp.push_back(e);
                if (trig_idx < 0 && e.pc == trig) trig_idx = smp.size() - 1;
                if (trig_idx >= 0 && smp.size() - 1 == trig_idx + POST_CNT - 1) done = 1'b1;
            end
            @(posedge clk); #1;
            pcv += 32'd4;
            cyc++;
            if (done) break;
        end
        cap_en = 1'b0;
        if (!done) begin
            chk("capture_timeout", 32'd1, 32'd0);
            return;
        end
        keep = (smp.size() < DEPTH) ? smp.size() : DEPTH;
        for (int i = smp.size() - keep; i < smp.size(); i++) exp_q.push_back(smp[i]);
        chk("cap_state", 32'(state_o), 32'd3);
        chk("cap_count", 32'(count_o), 32'(keep));
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic drain(input int mode, input bit arm_test, input int exp_cnt);
        int k = 0;
        if (arm_test) begin
            rd_ready = 1'b0;
            arm      = 1'b1;
            cap_en   = 1'b1;
            pc_in    = trig_pc;
            @(posedge clk); #1;
            arm    = 1'b0;
            cap_en = 1'b0;
            chk("arm_in_drain_state", 32'(state_o), 32'd3);
            chk("arm_in_drain_count", 32'(count_o), 32'(exp_cnt));
        end
        while (exp_q.size() != 0 && k < 200) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (k % 4 == 0) || (k % 4 == 3);
                default: rd_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(posedge clk); #1;
            k++;
        end
        rd_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("idle_after_drain", 32'(state_o), 32'd0);
        chk("valid_after_drain", 32'(rd_valid), 32'd0);
        chk("count_held", 32'(count_o), 32'(exp_cnt));
        exp_q.delete();
    endtask

    initial begin
        int n;
        #3;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_pc", rd_pc, 32'd0);
        chk("rst_last", 32'(rd_last), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        capture(32'h28, 0, 1'b0, n);
        chk("wrap_keep", 32'(n), 32'd8);
        drain(0, 1'b0, n);

        // Trigger match in IDLE must be ignored and must not disturb count_o.
        cap_en = 1'b1;
        pc_in  = trig_pc;
        @(posedge clk); #1;
        cap_en = 1'b0;
        chk("idle_trig_state", 32'(state_o), 32'd0);
        chk("idle_trig_count", 32'(count_o), 32'd8);

        capture(32'h08, 0, 1'b0, n);
        chk("short_keep", 32'(n), 32'd5);
        drain(0, 1'b0, n);

        capture(32'h28, 0, 1'b0, n);
        drain(1, 1'b1, n);

        capture(32'h20, 2, 1'b0, n);
        drain(2, 1'b0, n);

        capture(32'h10, 0, 1'b1, n);
        capture(32'h0C, 0, 1'b0, n);
        drain(0, 1'b0, n);

        for (int r = 0; r < 6; r++) begin
            capture(32'(4 * $urandom_range(0, 20)), int'($urandom_range(0, 2)), 1'b0, n);
            drain(int'($urandom_range(0, 2)), 1'b0, n);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
